// File: rtl/tli4970_pkg.sv
// Shared definitions for the TLI4970 SPI responder: state encoding, frame layout and defaults.
package tli4970_pkg;

    localparam int unsigned FRAME_BITS             = 16;
    localparam int unsigned DATA_BITS              = 13;
    localparam int unsigned CNT_BITS               = 4;
    localparam int unsigned COUNT_BITS             = 16;
    localparam int unsigned DEFAULT_CURRENT_OFFSET = 4096;

    localparam int unsigned MSG_TYPE_BIT = 15;
    localparam int unsigned PARITY_BIT   = 14;
    localparam int unsigned OCD_BIT      = 13;
    localparam int unsigned DATA_MSB     = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tli4970_spi_responder_spi_input_sync.sv
// Two-flop synchroniser plus history flop for sclk and ss_n, producing single-cycle edge strobes.
module spi_input_sync
    import tli4970_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic ss_n,
    output logic sclk_fall_c,
    output logic ss_fall_c,
    output logic ss_rise_c
);

    logic [1:0] sclk_sync;
    logic       sclk_hist;
    logic [1:0] ss_sync;
    logic       ss_hist;

    // ss chain resets low so a select still held after reset never looks like a fresh fall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            sclk_hist <= 1'b0;
            ss_sync   <= 2'b00;
            ss_hist   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            sclk_hist <= sclk_sync[1];
            ss_sync   <= {ss_sync[0], ss_n};
            ss_hist   <= ss_sync[1];
        end
    end

    assign sclk_fall_c = sclk_hist & ~sclk_sync[1];
    assign ss_fall_c   = ss_hist & ~ss_sync[1];
    assign ss_rise_c   = ~ss_hist & ss_sync[1];

endmodule

// File: rtl/tli4970_spi_responder.sv
// SPI slave emulating a TLI4970 current sensor; serves 16-bit current or status frames.
// Optional odd parity in bit14 is built when TLI4970_RESPONDER_PARITY_EN is defined.
module tli4970_spi_responder
    import tli4970_pkg::*;
#(
    parameter int unsigned FRAME_BITS     = tli4970_pkg::FRAME_BITS,
    parameter int unsigned CURRENT_OFFSET = DEFAULT_CURRENT_OFFSET
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        ss_n,
    output logic        miso,
    output logic        miso_oe,
    input  logic [12:0] current_in,
    input  logic        ocd_in,
    input  logic        value_valid,
    input  logic        status_req,
    input  logic [12:0] status_in,
    output logic        frame_done,
    output logic        frame_error,
    output logic [15:0] frames_served
);

    localparam int unsigned LAST_BIT = FRAME_BITS - 1;

    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;

    spi_input_sync u_sync (
        .clock       (clock),
        .reset       (reset),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .sclk_fall_c (sclk_fall),
        .ss_fall_c   (ss_fall),
        .ss_rise_c   (ss_rise)
    );

    state_t                  state, state_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [CNT_BITS-1:0]     bit_cnt, cnt_next;
    logic                    miso_next;
    logic                    frame_done_next;
    logic                    frame_error_next;
    logic [COUNT_BITS-1:0]   served_next;
    logic                    status_pending, status_pending_next;
    logic [DATA_BITS-1:0]    pend_current;
    logic                    pend_ocd;
    logic [FRAME_BITS-1:0]   frame_word;

    // Frame assembly from the pending registers, sampled only when LOAD commits it
    always_comb begin
        frame_word = '0;
        if (status_pending) begin
            frame_word[MSG_TYPE_BIT]  = 1'b1;
            frame_word[DATA_MSB:0]    = status_in;
        end else begin
            frame_word[OCD_BIT]       = pend_ocd;
            frame_word[DATA_MSB:0]    = pend_current + DATA_BITS'(CURRENT_OFFSET);
        end
`ifdef TLI4970_RESPONDER_PARITY_EN
        frame_word[PARITY_BIT] = ~(^frame_word);
`endif
    end

    // Next-state and output logic
    always_comb begin
        state_next          = state;
        shift_next          = shift_reg;
        cnt_next            = bit_cnt;
        miso_next           = 1'b0;
        frame_done_next     = 1'b0;
        frame_error_next    = 1'b0;
        served_next         = frames_served;
        status_pending_next = status_pending;

        if (ss_rise && (state == ST_LOAD || state == ST_SHIFT)) begin
            state_next       = ST_IDLE;
            frame_error_next = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_next = frame_word;
                    cnt_next   = '0;
                    miso_next  = frame_word[FRAME_BITS-1];
                    state_next = ST_SHIFT;
                    if (status_pending) begin
                        status_pending_next = 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_fall) begin
                        shift_next = {shift_reg[FRAME_BITS-2:0], 1'b0};
                        cnt_next   = CNT_BITS'(bit_cnt + 1'b1);
                        if (bit_cnt == CNT_BITS'(LAST_BIT)) begin
                            state_next = ST_DONE;
                        end
                    end
                    miso_next = (state_next == ST_DONE) ? 1'b0 : shift_next[FRAME_BITS-1];
                end
                ST_DONE: begin
                    if (ss_rise) begin
                        frame_done_next = 1'b1;
                        served_next     = COUNT_BITS'(frames_served + 1'b1);
                        state_next      = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // A request arriving during LOAD must survive the clear above
        if (status_req) begin
            status_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            miso           <= 1'b0;
            miso_oe        <= 1'b0;
            frame_done     <= 1'b0;
            frame_error    <= 1'b0;
            frames_served  <= '0;
            status_pending <= 1'b0;
            pend_current   <= '0;
            pend_ocd       <= 1'b0;
        end else begin
            state          <= state_next;
            shift_reg      <= shift_next;
            bit_cnt        <= cnt_next;
            miso           <= miso_next;
            miso_oe        <= (state_next != ST_IDLE);
            frame_done     <= frame_done_next;
            frame_error    <= frame_error_next;
            frames_served  <= served_next;
            status_pending <= status_pending_next;
            if (value_valid) begin
                pend_current <= current_in;
                pend_ocd     <= ocd_in;
            end
        end
    end

endmodule
